// File: rtl/phy_pkg.sv
// Symbols and receiver state encoding shared by the serial link transmit and receive sides.
package phy_pkg;

  localparam logic [7:0] COMMA_SYM = 8'hBC;
  localparam logic [7:0] IDLE_SYM  = 8'h7C;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    ALIGNED = 2'd1,
    LOCKED  = 2'd2
  } phy_state_e;

endpackage

// File: rtl/phy_comma_detect.sv
// Serial-to-parallel shifter with a sliding 8-bit window and comma/idle symbol matching.
module phy_comma_detect
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_SYM,
  parameter logic [7:0] IDLE  = IDLE_SYM
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  output logic [7:0] nsr,
  output logic       is_comma,
  output logic       is_idle
);

  // Only the seven newest bits are kept: the oldest bit of the window is
  // shifted out on the same edge the window is evaluated, so it is never read.
  logic [6:0] sr_q;
  logic [6:0] sr_d;

  always_comb begin
    sr_d = {sr_q[5:0], serial_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign nsr      = {sr_q, serial_in};
  assign is_comma = (nsr == COMMA);
  assign is_idle  = (nsr == IDLE);

endmodule

// File: rtl/serial_rx_aligner.sv
// Serial receiver: finds comma byte alignment, locks after LOCK_COUNT aligned commas, delivers data bytes.
module serial_rx_aligner
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_SYM,
  parameter logic [7:0] IDLE       = IDLE_SYM,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       SerialIn,
  output logic       active,
  output logic [7:0] dataOut,
  output logic       validOut
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  logic [7:0] nsr;
  logic       is_comma;
  logic       is_idle;

  phy_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       boundary;

  phy_comma_detect #(
    .COMMA (COMMA),
    .IDLE  (IDLE)
  ) u_comma_detect (
    .clk       (clk_32f),
    .rst_n     (reset),
    .serial_in (SerialIn),
    .nsr       (nsr),
    .is_comma  (is_comma),
    .is_idle   (is_idle)
  );

  assign boundary = (bit_cnt_q == 3'd7);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q     <= INIT;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    case (state_q)
      INIT: begin
        if (is_comma) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 4'd1;
          state_d     = (LOCK_CNT == 4'd1) ? LOCKED : ALIGNED;
        end
      end
      ALIGNED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_d == LOCK_CNT) begin
              state_d = LOCKED;
            end
          end else begin
            // Misaligned byte: restart the sliding search from the next bit.
            comma_cnt_d = 4'd0;
            state_d     = INIT;
          end
        end
      end
      LOCKED: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Outputs only move on locked byte boundaries; fillers drop valid but keep the last byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (state_q == LOCKED && boundary) begin
      if (!is_comma && !is_idle) begin
        data_d  = nsr;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  assign active   = (state_q == LOCKED);
  assign dataOut  = data_q;
  assign validOut = valid_q;

endmodule

// File: doc/serial_rx_aligner.md
SERIAL_RX_ALIGNER -- requirements
Module: serial_rx_aligner

Interface
REQ-001 Parameter COMMA, default 8'hBC: alignment symbol.
REQ-002 Parameter IDLE, default 8'h7C: filler symbol, never delivered as data.
REQ-003 Parameter LOCK_COUNT, default 4, legal 1..15: consecutive aligned COMMAs required for lock.
REQ-004 clk_32f  input  1: bit clock; all state changes on its rising edge.
REQ-005 reset  input  1: asynchronous, active-low (0 = reset).
REQ-006 SerialIn  input  1: serial bit stream, MSB first, one bit per clk_32f cycle.
REQ-007 active  output  1: link locked.
REQ-008 dataOut  output  8: last delivered data byte.
REQ-009 validOut  output  1: dataOut holds a data byte for the current byte period.

Function
REQ-010 Shift register sr SHALL update every edge as sr <= {sr[6:0], SerialIn}; nsr denotes that next value.
REQ-011 States: INIT, ALIGNED, LOCKED; a 3-bit bit counter bit_cnt and a 4-bit comma counter comma_cnt SHALL be kept.
REQ-012 INIT: each edge, if nsr == COMMA then bit_cnt <= 0 and comma_cnt <= 1; next state is LOCKED if LOCK_COUNT == 1, else ALIGNED. Otherwise stay in INIT.
REQ-013 ALIGNED/LOCKED: bit_cnt SHALL increment mod 8 each edge; the edge where bit_cnt == 7 is the byte boundary and nsr is the completed byte.
REQ-014 ALIGNED boundary, byte == COMMA: comma_cnt increments; on reaching LOCK_COUNT, go LOCKED.
REQ-015 ALIGNED boundary, byte != COMMA: go INIT and clear comma_cnt; search resumes on the next edge.
REQ-016 active SHALL be 1 exactly while in LOCKED and SHALL rise on the boundary edge completing the LOCK_COUNT-th comma.
REQ-017 Once LOCKED, the block SHALL stay LOCKED until reset; there is no loss-of-lock detection.
REQ-018 LOCKED boundary, byte not COMMA and not IDLE: dataOut <= byte and validOut <= 1 on that same edge (zero latency after the last bit).
REQ-019 LOCKED boundary, byte is COMMA or IDLE: validOut <= 0 and dataOut holds its previous value.
REQ-020 dataOut and validOut SHALL change only on LOCKED boundary edges, so each value is held for 8 cycles.
REQ-021 In INIT and ALIGNED, validOut SHALL be 0.

Reset
REQ-022 While reset == 0, these values SHALL apply immediately, independent of clk_32f: state INIT, sr 0, bit_cnt 0, comma_cnt 0, active 0, dataOut 8'h00, validOut 0.
REQ-023 Reset asserted mid-byte or while LOCKED SHALL discard all alignment; relock needs LOCK_COUNT fresh commas.
REQ-024 The first sampled bit is on the first rising edge after reset deasserts.

Structure
REQ-025 A shared package phy_pkg SHALL hold the COMMA and IDLE symbol constants and the state encoding (INIT=2'd0, ALIGNED=2'd1, LOCKED=2'd2), shared with the transmit-side serializer.
REQ-026 Sub-module phy_comma_detect SHALL hold sr and provide nsr, is_comma and is_idle; serial_rx_aligner holds the FSM, counters and output registers.

Verification
REQ-027 Reset, then 4×8'hBC then 8'h55: active rises on the edge sampling the 32nd bit; on edge 40, dataOut=8'h55 and validOut=1, both held 8 cycles.
REQ-028 Reset, then 3 bits 3'b101, then 4×8'hBC, 8'hA3: alignment found at bit offset 3; active rises on edge 35; dataOut=8'hA3 and validOut=1 on edge 43.
REQ-029 3×8'hBC, 8'h12, 4×8'hBC: active stays 0 through the 8'h12 byte; active rises only on the boundary completing the final comma (edge 64).
REQ-030 LOCKED with dataOut=8'h55, then send 8'h7C then 8'hBC: validOut=0 for both byte periods and dataOut stays 8'h55.
REQ-031 LOCKED, reset driven low mid-byte (e.g. edge 3 of the byte): active, validOut and dataOut go 0 without a clock edge; after release, 3×8'hBC leaves active at 0 and the 4th comma sets it.
REQ-032 SerialIn held 0 for 200 cycles, then held 1 for 200 cycles: active and validOut stay 0 throughout.
